// File: rtl/tensor_mm_pkg.sv
// Shared definitions for the tensor-matrix multiply datapath: default widths,
// element/accumulator types and the index-width helper.
package tensor_mm_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 48;

  typedef logic signed [ACC_W_DEF-1:0]  acc_t;
  typedef logic signed [DATA_W_DEF-1:0] elem_t;

  function automatic int idx_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/tensor_idx_counter.sv
// Wrapping (n, m, l) coordinate counter, l fastest; shared with the upstream
// operand sequencer. last flags the final coordinate of the tensor.
module tensor_idx_counter
  import tensor_mm_pkg::*;
#(
  parameter int N_DIM = 2,
  parameter int M_DIM = 2,
  parameter int L_DIM = 2,
  parameter int NW    = idx_w(N_DIM),
  parameter int MW    = idx_w(M_DIM),
  parameter int LW    = idx_w(L_DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [NW-1:0] n,
  output logic [MW-1:0] m,
  output logic [LW-1:0] l,
  output logic          last
);

  logic [NW-1:0] n_q, n_d;
  logic [MW-1:0] m_q, m_d;
  logic [LW-1:0] l_q, l_d;
  logic          n_wrap, m_wrap, l_wrap;

  assign n_wrap = (n_q == NW'(N_DIM - 1));
  assign m_wrap = (m_q == MW'(M_DIM - 1));
  assign l_wrap = (l_q == LW'(L_DIM - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    n_d = n_q;
    m_d = m_q;
    l_d = l_q;
    if (adv) begin
      if (l_wrap) begin
        l_d = '0;
        if (m_wrap) begin
          m_d = '0;
          n_d = n_wrap ? '0 : n_q + NW'(1);
        end else begin
          m_d = m_q + MW'(1);
        end
      end else begin
        l_d = l_q + LW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= '0;
      m_q <= '0;
      l_q <= '0;
    end else begin
      n_q <= n_d;
      m_q <= m_d;
      l_q <= l_d;
    end
  end

  assign n    = n_q;
  assign m    = m_q;
  assign l    = l_q;
  assign last = n_wrap && m_wrap && l_wrap;

endmodule

// File: rtl/tensor_matmul_accumulator.sv
// Sums runs of K_DIM signed partial products into tensor elements, emitted with
// (n, m, l) coordinates. Define TENSOR_ACC_SAT_EN for saturation and sat_flag.
module tensor_matmul_accumulator
  import tensor_mm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_DIM  = 4,
  parameter int N_DIM  = 2,
  parameter int M_DIM  = 2,
  parameter int L_DIM  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prod_valid,
  input  logic [DATA_W-1:0]          prod_data,
  output logic                       prod_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [idx_w(N_DIM)-1:0]    out_n,
  output logic [idx_w(M_DIM)-1:0]    out_m,
  output logic [idx_w(L_DIM)-1:0]    out_l,
  output logic                       out_last
`ifdef TENSOR_ACC_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int KW = idx_w(K_DIM);
  localparam int NW = idx_w(N_DIM);
  localparam int MW = idx_w(M_DIM);
  localparam int LW = idx_w(L_DIM);

  logic [KW-1:0]             k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   ext, sum;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic [NW-1:0]             out_n_q, out_n_d, cur_n;
  logic [MW-1:0]             out_m_q, out_m_d, cur_m;
  logic [LW-1:0]             out_l_q, out_l_d, cur_l;
  logic                      out_last_q, out_last_d, cur_last;
  logic                      accept, fin;
  logic [DATA_W-1:0]         elem;
`ifdef TENSOR_ACC_SAT_EN
  logic                      sat_q, sat_d, ovf;
`endif

  assign prod_ready = !rst && !(out_valid_q && !out_ready);
  assign accept     = prod_valid && prod_ready;
  assign fin        = accept && (k_q == KW'(K_DIM - 1));

  assign ext = {{(ACC_W-DATA_W){prod_data[DATA_W-1]}}, prod_data};
  // k==0 starts a fresh element, which also covers K_DIM==1.
  assign sum = (k_q == '0) ? ext : acc_q + ext;

`ifdef TENSOR_ACC_SAT_EN
  assign ovf  = (sum[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){sum[ACC_W-1]}});
  assign elem = !ovf          ? sum[DATA_W-1:0] :
                sum[ACC_W-1]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign elem = sum[DATA_W-1:0];
`endif

  tensor_idx_counter #(
    .N_DIM (N_DIM),
    .M_DIM (M_DIM),
    .L_DIM (L_DIM)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .adv  (fin),
    .n    (cur_n),
    .m    (cur_m),
    .l    (cur_l),
    .last (cur_last)
  );

  always_comb begin
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_n_d     = out_n_q;
    out_m_d     = out_m_q;
    out_l_d     = out_l_q;
    out_last_d  = out_last_q;
`ifdef TENSOR_ACC_SAT_EN
    sat_d       = sat_q;
`endif
    if (accept) begin
      if (fin) begin
        k_d         = '0;
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = elem;
        out_n_d     = cur_n;
        out_m_d     = cur_m;
        out_l_d     = cur_l;
        out_last_d  = cur_last;
`ifdef TENSOR_ACC_SAT_EN
        sat_d       = sat_q || ovf;
`endif
      end else begin
        k_d   = k_q + KW'(1);
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_n_q     <= '0;
      out_m_q     <= '0;
      out_l_q     <= '0;
      out_last_q  <= 1'b0;
`ifdef TENSOR_ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_n_q     <= out_n_d;
      out_m_q     <= out_m_d;
      out_l_q     <= out_l_d;
      out_last_q  <= out_last_d;
`ifdef TENSOR_ACC_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_n     = out_n_q;
  assign out_m     = out_m_q;
  assign out_l     = out_l_q;
  assign out_last  = out_last_q;
`ifdef TENSOR_ACC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_tensor_matmul_accumulator.sv
// Directed bench for tensor_matmul_accumulator: a K=4 instance for the main
// scenarios and a K=1 instance for pass-through throughput.
module tb_tensor_matmul_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic [31:0] prod_data = '0;
  logic        prod_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_n, out_m, out_l, out_last;

  logic        k1_valid = 1'b0;
  logic [31:0] k1_data = '0;
  logic        k1_ready, k1_ovalid;
  logic        k1_oready = 1'b1;
  logic [31:0] k1_odata;
  logic        k1_n, k1_m, k1_l, k1_last;

`ifdef TENSOR_ACC_SAT_EN
  logic sat_flag, k1_sat;
  localparam logic [31:0] EXP_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tensor_matmul_accumulator #(.K_DIM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_n      (out_n),
    .out_m      (out_m),
    .out_l      (out_l),
    .out_last   (out_last)
`ifdef TENSOR_ACC_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  tensor_matmul_accumulator #(.K_DIM(1)) dut_k1 (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (k1_valid),
    .prod_data  (k1_data),
    .prod_ready (k1_ready),
    .out_valid  (k1_ovalid),
    .out_ready  (k1_oready),
    .out_data   (k1_odata),
    .out_n      (k1_n),
    .out_m      (k1_m),
    .out_l      (k1_l),
    .out_last   (k1_last)
`ifdef TENSOR_ACC_SAT_EN
    ,
    .sat_flag   (k1_sat)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one product from the falling edge and hold it until accepted.
  task automatic push(input logic [31:0] d);
    int w;
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = d;
    w = 0;
    while (!prod_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", {63'd0, prod_ready}, 64'd1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
  endtask

  task automatic push4(input logic [31:0] a, b, c, d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d,
                           input logic n, m, l, last);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_data"},  {32'd0, out_data}, {32'd0, d});
    check({tag, "_nml"},   {61'd0, out_n, out_m, out_l}, {61'd0, n, m, l});
    check({tag, "_last"},  {63'd0, out_last}, {63'd0, last});
  endtask

  logic [31:0] k1_vals [4] = '{32'd7, 32'hFFFF_FFFE, 32'd100, 32'h7FFF_FFFF};

  initial begin
    // Reset state while rst is held high.
    #12;
    check("rst_prod_ready", {63'd0, prod_ready}, 64'd0);
    check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_out_data",   {32'd0, out_data}, 64'd0);
    check("rst_nml_last",   {60'd0, out_n, out_m, out_l, out_last}, 64'd0);
    check("rst_k1_ready",   {63'd0, k1_ready}, 64'd0);
`ifdef TENSOR_ACC_SAT_EN
    check("rst_sat_flag",   {63'd0, sat_flag}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic sum 1+2+3+4 with idle gaps mid-element.
    push(32'd1);
    idle(2);
    push(32'd2);
    push(32'd3);
    idle(1);
    check("basic_no_early_valid", {63'd0, out_valid}, 64'd0);
    push(32'd4);
    check_out("basic", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("basic_drained", {63'd0, out_valid}, 64'd0);
`ifdef TENSOR_ACC_SAT_EN
    check("basic_sat_flag", {63'd0, sat_flag}, 64'd0);
`endif

    // Coordinate walk over a full 2x2x2 tensor and into the next one.
    do_reset();
    for (int e = 0; e < 9; e++) begin
      logic [2:0] c;
      c = 3'(e % 8);
      push4(32'd1, 32'd1, 32'd1, 32'd1);
      check_out($sformatf("walk%0d", e), 32'd4, c[2], c[1], c[0], e == 7);
    end

    // Back-pressure, then same-cycle drain and accept.
    do_reset();
    push4(32'd1, 32'd2, 32'd3, 32'd4);
    out_ready = 1'b0;
    idle(2);
    check_out("bp_hold", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_stall", {63'd0, prod_ready}, 64'd0);
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = 32'd5;
    #1;
    check("bp_still_stalled", {63'd0, prod_ready}, 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_ready_on_drain", {63'd0, prod_ready}, 64'd1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    push(32'd5); push(32'd5); push(32'd5);
    check_out("bp_next", 32'd20, 1'b0, 1'b0, 1'b1, 1'b0);

    // Signed sums: positive overflow, ordinary negative, negative overflow.
    do_reset();
    push4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0);
    check_out("ovf_pos", EXP_POS, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TENSOR_ACC_SAT_EN
    check("ovf_pos_sat", {63'd0, sat_flag}, 64'd1);
`endif
    push4(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF6, 32'd1);
    check_out("neg_sum", 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1, 1'b0);
    push4(32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    check_out("ovf_neg", EXP_NEG, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-element.
    do_reset();
    push4(32'd1, 32'd2, 32'd3, 32'd4);
    push(32'd9);
    push(32'd9);
    #2;
    rst = 1'b1;
    #1;
    check("amid_prod_ready", {63'd0, prod_ready}, 64'd0);
    check("amid_out_data",   {32'd0, out_data}, 64'd0);
    check("amid_nml_last",   {60'd0, out_n, out_m, out_l, out_last}, 64'd0);
`ifdef TENSOR_ACC_SAT_EN
    check("amid_sat_flag",   {63'd0, sat_flag}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    push4(32'd5, 32'd5, 32'd5, 32'd5);
    check_out("amid_after", 32'd20, 1'b0, 1'b0, 1'b0, 1'b0);

    // K_DIM=1: pass-through at one product per cycle.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] c;
      c = 2'(i);
      @(negedge clk);
      check($sformatf("k1_ready%0d", i), {63'd0, k1_ready}, 64'd1);
      k1_valid = 1'b1;
      k1_data  = k1_vals[i];
      @(posedge clk);
      #1;
      check($sformatf("k1_valid%0d", i), {63'd0, k1_ovalid}, 64'd1);
      check($sformatf("k1_data%0d", i),  {32'd0, k1_odata}, {32'd0, k1_vals[i]});
      check($sformatf("k1_ml%0d", i),    {62'd0, k1_m, k1_l}, {62'd0, c});
    end
    @(negedge clk);
    k1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tensor_matmul_accumulator.md
Name: tensor_matmul_accumulator

Overview:
- Downstream stage of the 3D tensor-matrix multiply datapath.
- Consumes the stream of signed 32-bit partial products from the multiply stage.
- Sums each run of K_DIM products into one output element C[n][m][l].
- Emits each element with its (n, m, l) coordinates over a ready/valid interface, with l varying fastest.

Parameters:
- DATA_W, 32: width of input products and output elements (two's complement).
- ACC_W, 48: internal accumulator width; must be > DATA_W.
- K_DIM, 4: inner (reduction) dimension, ≥1; number of products summed per output.
- N_DIM, 2: batch dimension of the output tensor, ≥1.
- M_DIM, 2: row dimension, ≥1.
- L_DIM, 2: column dimension, ≥1.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- prod_valid, input, 1: a product is offered on prod_data.
- prod_data, input, DATA_W: signed partial product.
- prod_ready, output, 1: block accepts the product this cycle.
- out_valid, output, 1: out_data and coordinates are valid.
- out_ready, input, 1: consumer accepts the output this cycle.
- out_data, output, DATA_W: finished element, signed.
- out_n, output, max(1,$clog2(N_DIM)): batch index of out_data.
- out_m, output, max(1,$clog2(M_DIM)): row index.
- out_l, output, max(1,$clog2(L_DIM)): column index.
- out_last, output, 1: element is C[N-1][M-1][L-1], the final element of the tensor.

Behaviour:
- Reset is asynchronous and active-high, on rst. While rst is high, all outputs and internal state are 0: prod_ready=0, out_valid=0, out_data=0, indices 0, out_last=0, accumulator 0, k counter 0.
- Reset asserted mid-element or mid-tensor discards the partial sum and restarts at k=0, coordinates (0,0,0).
- Product accept: occurs when prod_valid && prod_ready.
- prod_ready = !rst && !(out_valid && !out_ready). Input is stalled only while the output register is full and not draining. Simultaneous drain and fill in one cycle is allowed, so full throughput is 1 product per cycle.
- Accumulation:
  - Each product is sign-extended to ACC_W.
  - If k != K_DIM-1: acc <= (k==0 ? ext : acc+ext), and k <= k+1.
  - If k == K_DIM-1: the final sum (acc+ext, or ext alone when K_DIM=1) is converted to DATA_W and loaded into the output register. out_valid <= 1, and the current coordinates are captured. acc is cleared and k <= 0.
- Latency: out_valid rises on the cycle after the K_DIM-th product is accepted.
- Output hold: out_data, indices and out_last stay stable while out_valid && !out_ready.
- Output drain: out_valid clears after an accepted transfer, unless a new element loads in the same cycle, in which case it stays 1 with the new contents.
- Coordinate counters advance at each element completion:
  - l increments first.
  - l wraps from L_DIM-1 to 0 and carries into m.
  - m wraps from M_DIM-1 to 0 and carries into n.
  - n wraps from N_DIM-1 to 0.
  - After the last element, the counters return to (0,0,0) and the next tensor starts with no idle cycle.
- ACC_W → DATA_W conversion without the optional feature: wraps (low DATA_W bits kept).
- Idle prod_valid gaps mid-element do not disturb acc or k.

Optional Feature:
- Macro: TENSOR_ACC_SAT_EN.
- Defined: the final sum saturates to the signed DATA_W range (max 0x7FFFFFFF, min 0x80000000 for DATA_W=32). A sticky output port sat_flag (1 bit, reset 0) is added; it sets on any saturating element and clears only on rst.
- Undefined: wrap truncation, and no sat_flag port.

Decomposition:
- Shared package tensor_mm_pkg:
  - DATA_W and ACC_W defaults.
  - Index-width helper function idx_w(dim) = max(1,$clog2(dim)).
  - Typedef acc_t (signed ACC_W) and typedef elem_t (signed DATA_W).
- One sub-module tensor_idx_counter: the wrapping 3-level (n, m, l) counter with carry and last detection. It is reused by the upstream operand sequencer.

Test Plan:
- Basic sum: K=4, products 1,2,3,4 with out_ready=1 → out_data=10 at (0,0,0), out_valid one cycle after the 4th product, out_last=0.
- Coordinate walk: N=M=L=2, 8 elements of K=4 products all equal to 1 → out_data=4 each; coordinates in order (0,0,0),(0,0,1),(0,1,0)…(1,1,1); out_last=1 only on the 8th; a 9th element reports (0,0,0).
- Back-pressure: hold out_ready=0 after the first element completes → prod_ready=0, out_data stays 10; raise out_ready while the next product is offered → same-cycle drain+accept, no product lost.
- Signed/wrap: products 0x7FFFFFFF ×2, then 1, then 0 → without macro out_data=0xFFFFFFFF (wrapped, -1); with TENSOR_ACC_SAT_EN out_data=0x7FFFFFFF and sat_flag=1.
- Reset mid-operation: accept 2 of 4 products, pulse rst asynchronously → outputs 0; then products 5,5,5,5 → out_data=20 at (0,0,0).
- K_DIM=1 build: every accepted product appears unchanged on out_data the next cycle, at sustained 1 per cycle with out_ready=1.
